// File: rtl/video_timing_ctrl.sv
// Raster timing generator and pixel-source scheduler for the HDMI pipeline.
// Counters feed a one-cycle registered stage driving the TMDS encoder VD/VDE/CD inputs.
module video_timing_ctrl #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter logic [23:0] UF_COLOR = 24'hFF00FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        pix_ready,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        vde,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [10:0] cx,
  output logic [10:0] cy,
  output logic        busy,
  output logic        underflow,
  input  logic        uf_clr
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SS   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SE   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] V_SS   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SE   = 12'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t      state;
  logic        active;
  logic        hs_raw;
  logic        vs_raw;
  logic        h_end;
  logic        v_end;
  logic [23:0] rgb_next;
  logic [11:0] cx_w;
  logic [11:0] cy_w;

  always_comb begin
    busy     = (state != IDLE);
    cx_w     = {1'b0, cx};
    cy_w     = {1'b0, cy};
    active   = busy && (cx_w < H_ACT) && (cy_w < V_ACT);
    hs_raw   = busy && (cx_w >= H_SS) && (cx_w < H_SE);
    vs_raw   = busy && (cy_w >= V_SS) && (cy_w < V_SE);
    h_end    = (cx == H_LAST);
    v_end    = (cy == V_LAST);
    rgb_next = '0;
    if (active) rgb_next = pix_valid ? pix_data : UF_COLOR;
  end

  assign pix_ready = active;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cx          <= '0;
      cy          <= '0;
      vde         <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (en) state <= RUN;
        RUN:  if (!en) state <= STOP;
        // A re-raised en on the last pixel keeps running so the frame period has no gap.
        STOP: begin
          if (en)                 state <= RUN;
          else if (h_end && v_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Counters wrap to 0 at frame end, which is also the IDLE entry value.
      if (busy) begin
        if (h_end) begin
          cx <= '0;
          cy <= v_end ? '0 : cy + 11'd1;
        end else begin
          cx <= cx + 11'd1;
        end
      end

      vde         <= active;
      red         <= rgb_next[23:16];
      green       <= rgb_next[15:8];
      blue        <= rgb_next[7:0];
      hsync       <= hs_raw ? HS_POL : ~HS_POL;
      vsync       <= vs_raw ? VS_POL : ~VS_POL;
      frame_start <= active && (cx == '0) && (cy == '0);
      underflow   <= (active && !pix_valid) || (underflow && !uf_clr);
    end
  end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed bench for video_timing_ctrl on a 7x5 raster with active-low syncs.
// Hsync is active on cx=5, vsync on cy=3; active area is cx<4, cy<2; frame period 35.
module tb_video_timing_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        pix_valid = 1'b0;
  logic [23:0] pix_data = '0;
  logic        uf_clr = 1'b0;
  logic        pix_ready;
  logic [7:0]  red, green, blue;
  logic        vde, hsync, vsync, frame_start, busy, underflow;
  logic [10:0] cx, cy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  video_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .UF_COLOR(24'hFF00FF)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .red(red), .green(green), .blue(blue), .vde(vde),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start), .cx(cx), .cy(cy),
    .busy(busy), .underflow(underflow), .uf_clr(uf_clr)
  );

  typedef struct {
    logic        rst, en, pv, uc;
    logic [23:0] pd;
    int          cx, cy;
    logic        busy, rdy, vde;
    logic [23:0] rgb;
    logic        hs, vs, fs, uf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic pv, input logic uc,
                     input logic [23:0] pd, input int x, input int y,
                     input logic b, input logic rd, input logic de, input logic [23:0] rgb,
                     input logic hs, input logic vs, input logic fs, input logic uf);
    vec_t v;
    v.rst = r; v.en = e; v.pv = pv; v.uc = uc; v.pd = pd;
    v.cx = x; v.cy = y; v.busy = b; v.rdy = rd; v.vde = de; v.rgb = rgb;
    v.hs = hs; v.vs = vs; v.fs = fs; v.uf = uf;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges until frame_start is seen; limit+1 when it never appears.
  task automatic edges_to_fs(input int limit, output int n);
    n = limit + 1;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (frame_start) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".cx"}, 32'(cx), 32'd0);
    check({tag, ".cy"}, 32'(cy), 32'd0);
    check({tag, ".rdy"}, 32'(pix_ready), 32'd0);
    check({tag, ".vde"}, 32'(vde), 32'd0);
    check({tag, ".rgb"}, 32'({red, green, blue}), 32'd0);
    check({tag, ".hs"}, 32'(hsync), 32'd1);
    check({tag, ".vs"}, 32'(vsync), 32'd1);
    check({tag, ".fs"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    int n, k, hs_lo, vs_lo, de_hi, hs_first, vs_first;
    bit found;

    //   rst en pv uc data        cx cy busy rdy vde rgb        hs vs fs uf
    add(1, 0, 0, 0, 24'h000000, 0, 0, 0, 0, 0, 24'h000000, 1, 1, 0, 0);
    add(0, 0, 0, 0, 24'h000000, 0, 0, 0, 0, 0, 24'h000000, 1, 1, 0, 0);
    add(0, 1, 1, 0, 24'h123456, 0, 0, 1, 1, 0, 24'h000000, 1, 1, 0, 0);
    add(0, 1, 1, 0, 24'h123456, 1, 0, 1, 1, 1, 24'h123456, 1, 1, 1, 0);
    add(0, 1, 1, 0, 24'hABCDEF, 2, 0, 1, 1, 1, 24'hABCDEF, 1, 1, 0, 0);
    add(0, 1, 0, 0, 24'hABCDEF, 3, 0, 1, 1, 1, 24'hFF00FF, 1, 1, 0, 1);
    add(0, 1, 1, 0, 24'h111111, 4, 0, 1, 0, 1, 24'h111111, 1, 1, 0, 1);
    add(0, 1, 0, 0, 24'h222222, 5, 0, 1, 0, 0, 24'h000000, 1, 1, 0, 1);
    add(0, 1, 1, 1, 24'h222222, 6, 0, 1, 0, 0, 24'h000000, 0, 1, 0, 0);
    add(0, 1, 1, 0, 24'h333333, 0, 1, 1, 1, 0, 24'h000000, 1, 1, 0, 0);
    add(0, 1, 0, 1, 24'h444444, 1, 1, 1, 1, 1, 24'hFF00FF, 1, 1, 0, 1);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; en = vecs[i].en; pix_valid = vecs[i].pv;
      uf_clr = vecs[i].uc; pix_data = vecs[i].pd;
      tick();
      check($sformatf("v%0d.cx", i), 32'(cx), 32'(vecs[i].cx));
      check($sformatf("v%0d.cy", i), 32'(cy), 32'(vecs[i].cy));
      check($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("v%0d.rdy", i), 32'(pix_ready), 32'(vecs[i].rdy));
      check($sformatf("v%0d.vde", i), 32'(vde), 32'(vecs[i].vde));
      check($sformatf("v%0d.rgb", i), 32'({red, green, blue}), 32'(vecs[i].rgb));
      check($sformatf("v%0d.hs", i), 32'(hsync), 32'(vecs[i].hs));
      check($sformatf("v%0d.vs", i), 32'(vsync), 32'(vecs[i].vs));
      check($sformatf("v%0d.fs", i), 32'(frame_start), 32'(vecs[i].fs));
      check($sformatf("v%0d.uf", i), 32'(underflow), 32'(vecs[i].uf));
    end

    // Stop at (1,1): the raster finishes the frame, 27 more edges through (6,4).
    en = 1'b0; pix_valid = 1'b1; uf_clr = 1'b0; pix_data = 24'h5A5A5A;
    n = 101;
    for (int j = 1; j <= 100; j++) begin
      tick();
      if (!busy) begin
        n = j;
        break;
      end
    end
    check("stop_edges", 32'(n), 32'd27);
    check_idle("stop_idle");
    check("stop_uf_sticky", 32'(underflow), 32'd1);
    tick();
    check_idle("stop_idle2");

    // Restart and profile one full frame period.
    en = 1'b1;
    edges_to_fs(10, n);
    check("start_fs_latency", 32'(n), 32'd2);
    check("start_rgb", 32'({red, green, blue}), 32'h5A5A5A);
    hs_lo = 0; vs_lo = 0; de_hi = 0; hs_first = -1; vs_first = -1;
    k = 0; found = 1'b0;
    while (k < 100) begin
      if (!hsync) begin hs_lo++; if (hs_first < 0) hs_first = k; end
      if (!vsync) begin vs_lo++; if (vs_first < 0) vs_first = k; end
      if (vde) de_hi++;
      tick();
      k++;
      if (frame_start) begin
        found = 1'b1;
        break;
      end
    end
    check("period", 32'(found ? k : -1), 32'd35);
    check("hs_low_count", 32'(hs_lo), 32'd5);
    check("hs_first", 32'(hs_first), 32'd5);
    check("vs_low_count", 32'(vs_lo), 32'd7);
    check("vs_first", 32'(vs_first), 32'd21);
    check("vde_count", 32'(de_hi), 32'd8);

    // Brief en drop mid-frame: no raster disturbance, period unchanged.
    en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      check($sformatf("restop_busy%0d", j), 32'(busy), 32'd1);
    end
    en = 1'b1;
    edges_to_fs(100, n);
    check("restop_period_rest", 32'(n), 32'd32);

    // Reset at (3,1) mid-run with en held high.
    n = 0;
    while (!(cx == 11'd3 && cy == 11'd1) && n < 100) begin
      tick();
      n++;
    end
    check("reach_3_1", 32'(n < 100), 32'd1);
    pix_valid = 1'b0;
    tick();
    check("pre_rst_uf", 32'(underflow), 32'd1);
    rst = 1'b1;
    tick();
    check_idle("rst_idle");
    check("rst_uf", 32'(underflow), 32'd0);
    rst = 1'b0; pix_valid = 1'b1;
    edges_to_fs(10, n);
    check("rst_fs_latency", 32'(n), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
